// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for the sequenced 3-to-8 decoder.
//   state_t  - FSM encoding (IDLE / HOLD / GAP)
//   CNT_W    - width of the hold/gap cycle counter
//   onehot8  - 3-bit code to 8-bit one-hot word
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// decoder3to8: combinational 3-to-8 one-hot decoder with enable.
// Ports:
//   i_en     in   1  1 = drive the one-hot word, 0 = all zero
//   i_code   in   3  code to decode
//   o_onehot out  8  1 << i_code when enabled, else 8'h00
module decoder3to8
  import decoder_pkg::*;
(
  input  logic       i_en,
  input  logic [2:0] i_code,
  output logic [7:0] o_onehot
);

  always_comb begin
    o_onehot = 8'h00;
    if (i_en) begin
      o_onehot = onehot8(i_code);
    end
  end

endmodule

// File: rtl/decoder3to8_seq.sv
// decoder3to8_seq: sequenced 3-to-8 one-hot decoder.
// Takes 3-bit codes over a valid/ready handshake, drives 1<<code on D for
// HOLD_CYCLES cycles, then GAP_CYCLES all-zero cycles. One pending slot lets
// a second code be queued while the current one is being shown.
//
// Handshake: a code transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational (= !pend_valid) and does not depend on in_valid;
// the source may hold in_valid with stable Q until the transfer happens.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   en        in   1  1 = run; 0 = freeze state, counter and D
//   in_valid  in   1  Q carries a code
//   in_ready  out  1  pending slot is empty
//   Q         in   3  code to decode
//   D         out  8  registered one-hot output (zero outside HOLD)
//   busy      out  1  registered, 1 in HOLD or GAP
//   done      out  1  registered one-cycle pulse after the last HOLD cycle
//   dbg_state out  2  current FSM state (state_t encoding)
module decoder3to8_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] Q,
  output logic [7:0] D,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_active;
  logic             r_pend_valid;
  logic [2:0]       r_pend;
  logic [7:0]       r_d;
  logic             r_busy;
  logic             r_done;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [2:0]       w_next_active;
  logic             w_accept;
  logic             w_direct;
  logic             w_pend_take;
  logic             w_hold_last;
  logic             w_select;
  logic [7:0]       w_next_d;

  assign in_ready  = !r_pend_valid;
  assign w_accept  = in_valid && in_ready;
  // Only an idle, running block bypasses the pending slot.
  assign w_direct  = w_accept && (r_state == IDLE) && en;

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_active = r_active;
    w_pend_take   = 1'b0;
    w_hold_last   = 1'b0;
    w_select      = 1'b0;
    if (en) begin
      case (r_state)
        IDLE: begin
          if (r_pend_valid) begin
            w_next_state  = HOLD;
            w_next_active = r_pend;
            w_next_cnt    = '0;
            w_pend_take   = 1'b1;
          end else if (w_direct) begin
            w_next_state  = HOLD;
            w_next_active = Q;
            w_next_cnt    = '0;
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_hold_last = 1'b1;
            w_next_cnt  = '0;
            if (HAS_GAP) begin
              w_next_state = GAP;
            end else begin
              w_select = 1'b1;
            end
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_next_cnt = '0;
            w_select   = 1'b1;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      endcase

      // End of a hold/gap sequence: chain straight into a queued code.
      if (w_select) begin
        if (r_pend_valid) begin
          w_next_state  = HOLD;
          w_next_active = r_pend;
          w_pend_take   = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
    end
  end

  // D is registered from the next-state view so the one-hot word appears in
  // the same cycle the FSM enters HOLD.
  decoder3to8 u_dec (
    .i_en     (w_next_state == HOLD),
    .i_code   (w_next_active),
    .o_onehot (w_next_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_active <= 3'd0;
      r_d      <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_active <= w_next_active;
      r_d      <= w_next_d;
      r_busy   <= (w_next_state != IDLE);
      r_done   <= w_hold_last;
    end
  end

  // Take and accept are mutually exclusive: accept needs an empty slot,
  // take needs a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend       <= 3'd0;
    end else begin
      if (w_pend_take) begin
        r_pend_valid <= 1'b0;
      end
      if (w_accept && !w_direct) begin
        r_pend_valid <= 1'b1;
        r_pend       <= Q;
      end
    end
  end

  assign D         = r_d;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_decoder3to8_seq.sv
// tb_decoder3to8_seq: self-checking bench for decoder3to8_seq.
// Two instances: dut (HOLD=4, GAP=1) and dut0 (HOLD=4, GAP=0).
// Expected per-cycle words are queued when stimulus is driven and popped
// one per cycle at the falling edge.
// Word layout: [15] loopback care, [14:12] loopback code, [11] ready care,
//              [10] ready, [9:2] D, [1] busy, [0] done.
module tb_decoder3to8_seq;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid, in_ready, busy, done;
  logic [2:0] Q;
  logic [7:0] D;
  logic [1:0] dbg_state;

  logic       en0, in_valid0, in_ready0, busy0, done0;
  logic [2:0] Q0;
  logic [7:0] D0;
  logic [1:0] dbg_state0;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .Q(Q), .D(D), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .in_valid(in_valid0), .in_ready(in_ready0),
    .Q(Q0), .D(D0), .busy(busy0), .done(done0), .dbg_state(dbg_state0)
  );

  function automatic logic [W-1:0] mk(input logic [7:0] d, input logic b, input logic dn,
                                      input logic rc, input logic r,
                                      input logic lc, input logic [2:0] lb);
    return {lc, lb, rc, r, d, b, dn};
  endfunction

  // Behavioural 8-to-3 encoder used for the loopback check.
  function automatic logic [2:0] enc8(input logic [7:0] d);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 8; i++) if (d[i]) c = 3'(i);
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; Q = 3'd0;
    en0 = 1'b1; in_valid0 = 1'b0; Q0 = 3'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (D !== 8'h00) begin n_err++; $display("FAIL reset_D: got %h want 00", D); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    // Start a code, queue a second one, then reset mid-HOLD.
    @(negedge clk); in_valid = 1'b1; Q = 3'd6;
    @(negedge clk); Q = 3'd2;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pre_reset_ready: got %b want 0", in_ready); end
    n_cmp++; if (D !== 8'h40) begin n_err++; $display("FAIL pre_reset_D: got %h want 40", D); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (D !== 8'h00) begin n_err++; $display("FAIL async_D: got %h want 00", D); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL async_done: got %b want 0", done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({D, busy, done} !== 10'h000) begin
        n_err++; $display("FAIL post_reset_idle cyc%0d: D/busy/done=%h/%b/%b want 00/0/0", k, D, busy, done);
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    @(negedge clk); in_valid = 1'b1; Q = 3'd3;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      w = exp_q.pop_front();
      n_cmp++;
      if ({D, busy, done} !== w[9:0]) begin
        n_err++; $display("FAIL single t+%0d: D/busy/done=%h/%b/%b want %h/%b/%b", k, D, busy, done, w[9:2], w[1], w[0]);
      end
      if (w[11]) begin
        n_cmp++;
        if (in_ready !== w[10]) begin n_err++; $display("FAIL single_ready t+%0d: got %b want %b", k, in_ready, w[10]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    @(negedge clk); in_valid = 1'b1; Q = 3'd0;
    for (int k = 1; k <= 11; k++) begin
      logic [7:0] d; logic b, dn, rc, r;
      d  = (k <= 4) ? 8'h01 : (k >= 6 && k <= 9) ? 8'h80 : 8'h00;
      b  = (k <= 10);
      dn = (k == 5 || k == 10);
      rc = (k != 6);
      r  = (k == 1 || k >= 7);
      exp_q.push_back(mk(d, b, dn, rc, r, 1'b0, 3'd0));
    end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      n_cmp++;
      if ({D, busy, done} !== w[9:0]) begin
        n_err++; $display("FAIL b2b t+%0d: D/busy/done=%h/%b/%b want %h/%b/%b", k, D, busy, done, w[9:2], w[1], w[0]);
      end
      if (w[11]) begin
        n_cmp++;
        if (in_ready !== w[10]) begin n_err++; $display("FAIL b2b_ready t+%0d: got %b want %b", k, in_ready, w[10]); end
      end
      if (k == 1) Q = 3'd7;
      if (k == 2) in_valid = 1'b0;
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] w;
    logic [2:0] codes[9];
    int idx;
    for (int i = 0; i < 8; i++) codes[i] = 3'(i);
    codes[8] = 3'd4;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << codes[i];
      for (int h = 0; h < 4; h++) exp_q.push_back(mk(oh, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, codes[i]));
      exp_q.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    end
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    @(negedge clk); in_valid = 1'b1; Q = codes[0]; idx = 1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      n_cmp++;
      if ({D, busy, done} !== w[9:0]) begin
        n_err++; $display("FAIL sweep t+%0d: D/busy/done=%h/%b/%b want %h/%b/%b", k, D, busy, done, w[9:2], w[1], w[0]);
      end
      if (w[15]) begin
        n_cmp++;
        if (enc8(D) !== w[14:12]) begin n_err++; $display("FAIL sweep_loopback t+%0d: got %0d want %0d", k, enc8(D), w[14:12]); end
      end
      if (w[11]) begin
        n_cmp++;
        if (in_ready !== w[10]) begin n_err++; $display("FAIL sweep_ready t+%0d: got %b want %b", k, in_ready, w[10]); end
      end
      if (in_ready && idx < 9) begin
        in_valid = 1'b1; Q = codes[idx]; idx++;
      end else begin
        in_valid = 1'b0;
        Q = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic test_en_freeze();
    logic [W-1:0] w;
    @(negedge clk); in_valid = 1'b1; Q = 3'd5;
    for (int k = 1; k <= 7; k++) exp_q.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      w = exp_q.pop_front();
      n_cmp++;
      if ({D, busy, done} !== w[9:0]) begin
        n_err++; $display("FAIL en_freeze t+%0d: D/busy/done=%h/%b/%b want %h/%b/%b", k, D, busy, done, w[9:2], w[1], w[0]);
      end
      if (k == 2) en = 1'b0;
      if (k == 5) en = 1'b1;
    end
  endtask

  task automatic test_gap0();
    logic [W-1:0] w;
    @(negedge clk); in_valid0 = 1'b1; Q0 = 3'd1;
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] d; logic b, dn;
      d  = (k <= 4) ? 8'h02 : (k <= 8) ? 8'h04 : 8'h00;
      b  = (k <= 8);
      dn = (k == 5 || k == 9);
      exp_q.push_back(mk(d, b, dn, (k == 1), 1'b1, 1'b0, 3'd0));
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      n_cmp++;
      if ({D0, busy0, done0} !== w[9:0]) begin
        n_err++; $display("FAIL gap0 t+%0d: D/busy/done=%h/%b/%b want %h/%b/%b", k, D0, busy0, done0, w[9:2], w[1], w[0]);
      end
      if (w[11]) begin
        n_cmp++;
        if (in_ready0 !== w[10]) begin n_err++; $display("FAIL gap0_ready t+%0d: got %b want %b", k, in_ready0, w[10]); end
      end
      if (k == 1) Q0 = 3'd2;
      if (k == 2) in_valid0 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep();
    test_en_freeze();
    test_gap0();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
